// File: rtl/affine_tap_acc_pkg.sv
// affine_pkg: shared defaults and FSM state type for the affine tap accumulator.
//   DEF_TAPS   taps accumulated per output sample
//   DEF_PROD_W signed width of one MCM tap product
//   DEF_ACC_W  signed accumulator width
//   DEF_SHIFT  normalisation shift (coefficients sum to 64)
//   DEF_OUT_W  signed output sample width
//   state_t    ACCUM: collecting taps, HOLD: result presented on out_sample
package affine_pkg;

  localparam int unsigned DEF_TAPS   = 6;
  localparam int unsigned DEF_PROD_W = 17;
  localparam int unsigned DEF_ACC_W  = 20;
  localparam int unsigned DEF_SHIFT  = 6;
  localparam int unsigned DEF_OUT_W  = 11;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/affine_tap_acc_if.sv
// affine_tap_acc_if: tap-product input stream plus result output stream.
//   in_valid/in_ready   handshake for one tap product
//   in_prod, in_neg     signed product magnitude and coefficient sign
//   in_clear            synchronous abort of the sample in progress
//   out_valid/out_ready handshake for a finished sample
//   out_sample          rounded, normalised result
// modport master: the producer/consumer around the accumulator.
// modport slave : the accumulator itself.
interface affine_tap_acc_if
  import affine_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic                     in_neg;
  logic                     in_clear;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_sample;

  modport master (
    output in_valid, in_prod, in_neg, in_clear, out_ready,
    input  in_ready, out_valid, out_sample
  );

  modport slave (
    input  in_valid, in_prod, in_neg, in_clear, out_ready,
    output in_ready, out_valid, out_sample
  );

endinterface

// File: rtl/affine_tap_acc_round_clip.sv
// affine_round_clip: combinational round-half-up, arithmetic shift and
// narrowing of a finished accumulator value.
//   acc    : signed accumulator value (ACC_W)
//   sample : (acc + 2^(SHIFT-1)) >>> SHIFT narrowed to OUT_W
// Build option AFFINE_TAP_ACC_CLIP_EN: saturate to the OUT_W signed range;
// otherwise keep the OUT_W LSBs (two's-complement wrap).
module affine_round_clip
  import affine_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned SHIFT = DEF_SHIFT,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sample
);

  // One guard bit so the rounding bias can never overflow the sum.
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) << (SHIFT - 1);

  logic signed [SUM_W-1:0] biased;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    biased  = $signed({acc[ACC_W-1], acc}) + ROUND;
    shifted = biased >>> SHIFT;
  end

`ifdef AFFINE_TAP_ACC_CLIP_EN
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

  always_comb begin
    if (shifted > MAXV) begin
      sample = OUT_W'(MAXV);
    end else if (shifted < MINV) begin
      sample = OUT_W'(MINV);
    end else begin
      sample = OUT_W'(shifted);
    end
  end
`else
  always_comb begin
    sample = OUT_W'(shifted);
  end
`endif

endmodule

// File: rtl/affine_tap_acc.sv
// affine_tap_acc: accumulates TAPS signed MCM tap products (each added or
// subtracted by in_neg), then rounds/normalises the sum and presents it on
// out_sample with a valid/ready handshake.
//   clk  : single clock, all state on rising edge
//   rst  : asynchronous, active-high reset
//   bus  : affine_tap_acc_if.slave (tap input stream, result output stream)
// Build option AFFINE_TAP_ACC_CLIP_EN selects saturation in affine_round_clip.
module affine_tap_acc
  import affine_pkg::*;
#(
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned SHIFT  = DEF_SHIFT,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic           clk,
  input  logic           rst,
  affine_tap_acc_if.slave bus
);

  localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;

  logic                    xfer;
  logic                    last_tap;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] rounded;

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_sample = sample_q;
  assign bus.in_ready   = (!bus.out_valid || bus.out_ready) && !bus.in_clear;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign last_tap = (cnt_q == CNT_W'(TAPS - 1));

  // Tap 0 starts from zero rather than the previous acc, so a new sample can
  // begin on the same edge the previous result is handed off.
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    acc_sum  = ((cnt_q == '0) ? '0 : acc_q) + (bus.in_neg ? -prod_ext : prod_ext);
  end

  affine_round_clip #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_clip (
    .acc    (acc_sum),
    .sample (rounded)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    if (bus.in_clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if ((state_q == HOLD) && bus.out_ready) begin
        state_d = ACCUM;
      end
      if (xfer) begin
        acc_d = acc_sum;
        if (last_tap) begin
          cnt_d    = '0;
          state_d  = HOLD;
          sample_d = rounded;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_affine_tap_acc.sv
// Testbench for affine_tap_acc: directed corner cases plus randomized traffic
// against a transaction-level reference model (tap list summed per sample).
module tb_affine_tap_acc;

  localparam int TAPS   = 6;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 20;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 11;

  logic clk;
  logic rst;

  affine_tap_acc_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

  affine_tap_acc #(
    .TAPS   (TAPS),
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of accepted taps of the current sample, and the
  // pending result.
  longint m_taps[$];
  bit     m_ov = 1'b0;
  longint m_os = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Rounded, normalised result of a full tap sum as the spec defines it.
  function automatic longint expect_out(input longint s);
    longint b, q, span;
    b = s + (longint'(1) <<< (SHIFT - 1));
    if (b >= 0) q = b / (longint'(1) <<< SHIFT);
    else        q = -((-b + (longint'(1) <<< SHIFT) - 1) / (longint'(1) <<< SHIFT));
`ifdef AFFINE_TAP_ACC_CLIP_EN
    if (q > (longint'(1) <<< (OUT_W - 1)) - 1) q = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (q < -(longint'(1) <<< (OUT_W - 1)))    q = -(longint'(1) <<< (OUT_W - 1));
`else
    span = longint'(1) <<< OUT_W;
    q = q % span;
    if (q < 0) q += span;
    if (q >= span / 2) q -= span;
`endif
    return q;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_neg    = 1'b0;
    bus.in_clear  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic cycle(input bit iv, input longint p, input bit neg, input bit clr, input bit ordy);
    bit     exp_rdy;
    longint sum;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_prod   = PROD_W'(p);
    bus.in_neg    = neg;
    bus.in_clear  = clr;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (!m_ov || ordy) && !clr;
    check_eq("in_ready", longint'(bus.in_ready), longint'(exp_rdy));
    @(posedge clk);
    if (clr) begin
      m_taps.delete();
      m_ov = 1'b0;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (iv && exp_rdy) begin
        m_taps.push_back(neg ? -p : p);
        if (m_taps.size() == TAPS) begin
          sum = 0;
          foreach (m_taps[i]) sum += m_taps[i];
          m_os = expect_out(sum);
          m_ov = 1'b1;
          m_taps.delete();
        end
      end
    end
    #1;
    check_eq("out_valid", longint'(bus.out_valid), longint'(m_ov));
    if (m_ov) check_eq("out_sample", longint'(bus.out_sample), m_os);
  endtask

  // Feed one full sample whose taps are given by first + (TAPS-1) * rest.
  task automatic sample(input longint first, input longint rest, input bit neg);
    cycle(1'b1, first, neg, 1'b0, 1'b1);
    for (int i = 1; i < TAPS; i++) cycle(1'b1, rest, neg, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #2;
    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_out_sample", longint'(bus.out_sample), 0);
    @(negedge clk);
    rst = 1'b0;
    m_taps.delete();
    m_ov = 1'b0;
    m_os = 0;
    #1;
    check_eq("rst_in_ready", longint'(bus.in_ready), 1);
  endtask

  initial begin
    longint p;
    rst = 1'b1;
    drive_idle();
    #2;
    check_eq("por_out_valid", longint'(bus.out_valid), 0);
    check_eq("por_out_sample", longint'(bus.out_sample), 0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("por_in_ready", longint'(bus.in_ready), 1);

    // 6 positive taps summing to 6400 -> 100.
    sample(1400, 1000, 1'b0);
    check_eq("sum6400", longint'(bus.out_sample), 100);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Rounding: 32 -> 1, -32 -> 0, -33 -> -1.
    sample(32, 0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    sample(32, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    sample(33, 0, 1'b1);
    check_eq("round_m33", longint'(bus.out_sample), -1);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // 128000 -> 1023 with saturation, -48 with wrap.
    sample(21335, 21333, 1'b0);
`ifdef AFFINE_TAP_ACC_CLIP_EN
    check_eq("sum128000", longint'(bus.out_sample), 1023);
`else
    check_eq("sum128000", longint'(bus.out_sample), -48);
`endif

    // Back-pressure: result held 5 cycles while taps wait, then tap 0 of the
    // next sample is accepted on the release cycle.
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    sample(500, 700, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 123, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TAPS; i++) cycle(1'b1, 640, 1'b0, 1'b0, 1'b1);
    check_eq("after_stall", longint'(bus.out_sample), 60);

    // Clear after tap 3 with a concurrent tap; next sample has no residue.
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 9999, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 9999, 1'b0, 1'b1, 1'b1);
    sample(64, 64, 1'b0);
    check_eq("after_clear", longint'(bus.out_sample), 6);

    // Reset mid-sample and during HOLD.
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5000, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    sample(640, 640, 1'b0);
    check_eq("post_rst_mid", longint'(bus.out_sample), 60);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    sample(64, 0, 1'b0);

    // Randomized traffic over the full signed product range.
    for (int i = 0; i < 600; i++) begin
      p = longint'($urandom_range(0, (1 << PROD_W) - 1));
      if (p >= (1 << (PROD_W - 1))) p -= (1 << PROD_W);
      if ($urandom_range(0, 7) == 0) p = ($urandom_range(0, 1) == 1) ? (1 << (PROD_W - 1)) - 1 : -(1 << (PROD_W - 1));
      cycle($urandom_range(0, 9) < 7, p, $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/affine_tap_acc.md
AFFINE_TAP_ACC -- requirements
Module: affine_tap_acc

Interface
REQ-001 Parameter TAPS, default 6: filter taps accumulated per output sample.
REQ-002 Parameter PROD_W, default 17: signed width of one MCM tap product.
REQ-003 Parameter ACC_W, default 20: signed accumulator width.
REQ-004 Parameter SHIFT, default 6: normalisation shift, since coefficients sum to 64.
REQ-005 Parameter OUT_W, default 11: signed output sample width.
REQ-006 Port clk, input, 1: single clock; all state on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port in_valid, input, 1: the product on in_prod is valid.
REQ-009 Port in_ready, output, 1: the block accepts a product this cycle.
REQ-010 Port in_prod, input, PROD_W: signed MCM product magnitude for the current tap.
REQ-011 Port in_neg, input, 1: the coefficient for this tap is negative; subtract in_prod.
REQ-012 Port in_clear, input, 1: synchronous abort of the current sample.
REQ-013 Port out_valid, output, 1: out_sample holds a finished result.
REQ-014 Port out_ready, input, 1: downstream accepts out_sample.
REQ-015 Port out_sample, output, OUT_W: rounded, normalised filtered sample.

Function
REQ-016 A tap transfer occurs when in_valid and in_ready are both high on a clock edge.
REQ-017 in_ready shall equal (!out_valid || out_ready) && !in_clear.
REQ-018 FSM states: ACCUM (tap_cnt 0..TAPS-1) and HOLD (out_valid high).
REQ-019 On a transfer with tap_cnt==0: acc loads ±sext(in_prod); otherwise acc becomes acc ± sext(in_prod); sign is selected by in_neg.
REQ-020 tap_cnt increments per transfer; on the TAPS-th transfer it wraps to 0, the state goes to HOLD and out_valid rises the next cycle (latency 1 cycle after the last tap).
REQ-021 out_sample = (acc_final + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed once and registered; it stays stable while out_valid && !out_ready.
REQ-022 In HOLD with out_ready high, out_valid drops next cycle unless the same edge completes a new TAPS-th tap.
REQ-023 A transfer in the same cycle as an output handshake starts the next sample (tap 0); no bubble is required.
REQ-024 in_clear: tap_cnt, acc and out_valid go to 0 next cycle; a concurrent in_valid tap is discarded; clear wins over every other event.
REQ-025 in_valid asserted while in_ready is low shall cause no state change.
REQ-026 With the default ACC_W, the accumulator cannot overflow for TAPS products of full PROD_W range.

Reset
REQ-027 While rst is high: out_valid=0, out_sample=0, tap_cnt=0, acc=0, state ACCUM; in_ready=1 when rst deasserts.
REQ-028 Reset mid-sample discards partial accumulation and any pending output.

Configuration
REQ-029 With AFFINE_TAP_ACC_CLIP_EN defined, the shifted value saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-030 Without AFFINE_TAP_ACC_CLIP_EN, the shifted value is truncated to its OUT_W LSBs (two's-complement wrap).

Structure
REQ-031 Package affine_pkg holds TAPS, PROD_W, ACC_W, SHIFT and OUT_W defaults plus the state enum {ACCUM, HOLD}.
REQ-032 One combinational sub-module, affine_round_clip, performs the rounding, shift and clip/truncate; the macro is evaluated only there.

Verification
REQ-033 Six taps, all positive, products summing to 6400 (e.g. 64*100 split across taps), out_ready=1 -> out_sample=100, out_valid 1 cycle after tap 6.
REQ-034 Tap sums of 32, -32 and -33 -> out_sample 1, 0 and -1 (round half up, arithmetic shift).
REQ-035 Sum 128000 -> 1023 with CLIP_EN, -48 without it.
REQ-036 out_ready=0 for 5 cycles after a result -> in_ready=0 and out_sample stable; on release, tap 0 of the next sample is accepted in the same cycle.
REQ-037 in_clear asserted after tap 3, concurrent with in_valid -> tap discarded; the next 6 taps produce a clean result with no residue.
REQ-038 rst pulsed mid-sample and during HOLD -> all outputs 0 and in_ready=1 after release.
